sram_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the team's 16×8 single-port SRAM: combinational read, synchronous write. Two masters each present valid/ready transactions. The arbiter selects at most one per cycle, with round-robin fairness and a bounded burst lock. It drives the SRAM's we/addr/wdata and returns registered read data to the originating requester. It sits between the masters and the SRAM in `sram_subsystem`.

---
 rtl/sram_arb_pkg.sv | 21 ++
 rtl/sram_arbiter.sv | 157 +++++++++++++++
 tb/tb_sram_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-requester SRAM arbiter.
// Holds the arbiter state encoding, requester id type and width defaults.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } arb_state_t;

    typedef logic req_id_t;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned CNT_W      = 4;

    function automatic arb_state_t own_state(input req_id_t id);
        return id ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Two-requester round-robin arbiter with bounded burst lock for a
// single-port SRAM (combinational read, synchronous write).
// Ports: clk, rst_n (async active-low); reqN_valid/ready/we/addr/wdata
// per requester; rspN_valid/rdata registered read returns;
// mem_we/mem_addr/mem_wdata drive the SRAM, mem_rdata comes back.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        st_q, st_d;
    req_id_t           last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rsp0_valid_q, rsp1_valid_q;
    logic [DATA_W-1:0] rsp0_rdata_q, rsp1_rdata_q;

    logic              win_vld;
    req_id_t           win_id;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              at_limit;

    assign at_limit = (cnt_q == CNT_W'(MAX_BURST));

    // Owner keeps the SRAM until its run hits the limit while the
    // other side waits; a solo requester is never forced off.
    always_comb begin
        win_vld = 1'b0;
        win_id  = last_q;
        case (st_q)
            OWN0: begin
                if (req0_valid && !(at_limit && req1_valid)) begin
                    win_vld = 1'b1;
                    win_id  = 1'b0;
                end else if (req1_valid) begin
                    win_vld = 1'b1;
                    win_id  = 1'b1;
                end else if (req0_valid) begin
                    win_vld = 1'b1;
                    win_id  = 1'b0;
                end
            end
            OWN1: begin
                if (req1_valid && !(at_limit && req0_valid)) begin
                    win_vld = 1'b1;
                    win_id  = 1'b1;
                end else if (req0_valid) begin
                    win_vld = 1'b1;
                    win_id  = 1'b0;
                end else if (req1_valid) begin
                    win_vld = 1'b1;
                    win_id  = 1'b1;
                end
            end
            default: begin
                if (req0_valid && req1_valid) begin
                    win_vld = 1'b1;
                    win_id  = ~last_q;
                end else if (req0_valid) begin
                    win_vld = 1'b1;
                    win_id  = 1'b0;
                end else if (req1_valid) begin
                    win_vld = 1'b1;
                    win_id  = 1'b1;
                end
            end
        endcase
        // Nothing is accepted while reset is held.
        if (!rst_n) begin
            win_vld = 1'b0;
        end
    end

    assign req0_ready = win_vld && (win_id == 1'b0);
    assign req1_ready = win_vld && (win_id == 1'b1);

    assign win_we    = win_id ? req1_we    : req0_we;
    assign win_addr  = win_id ? req1_addr  : req0_addr;
    assign win_wdata = win_id ? req1_wdata : req0_wdata;

    assign mem_we    = win_vld && win_we;
    assign mem_addr  = win_vld ? win_addr  : '0;
    assign mem_wdata = win_vld ? win_wdata : '0;

    always_comb begin
        st_d   = IDLE;
        last_d = last_q;
        cnt_d  = '0;
        if (win_vld) begin
            st_d   = own_state(win_id);
            last_d = win_id;
            if (st_q == own_state(win_id)) begin
                cnt_d = at_limit ? cnt_q : cnt_q + CNT_W'(1);
            end else begin
                cnt_d = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q         <= IDLE;
            last_q       <= 1'b1;
            cnt_q        <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            st_q         <= st_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            if (win_vld && !win_we) begin
                if (win_id) begin
                    rsp1_valid_q <= 1'b1;
                    rsp1_rdata_q <= mem_rdata;
                end else begin
                    rsp0_valid_q <= 1'b1;
                    rsp0_rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter with a behavioural SRAM and
// a reference model of the arbitration and memory contents.
module tb_sram_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req0_valid = 0, req0_we = 0;
    logic          req1_valid = 0, req1_we = 0;
    logic [AW-1:0] req0_addr = 0, req1_addr = 0;
    logic [DW-1:0] req0_wdata = 0, req1_wdata = 0;
    logic          req0_ready, req1_ready;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    logic [DW-1:0] sram [16];
    always @(posedge clk) if (mem_we) sram[mem_addr] <= mem_wdata;
    assign mem_rdata = sram[mem_addr];

    // reference model
    int            m_owner, m_run, m_last;
    logic [DW-1:0] m_mem [16];
    bit            e_v0, e_v1;
    logic [DW-1:0] e_d0, e_d1;
    int            checks = 0;
    int            failures = 0;

    task automatic model_reset();
        m_owner = -1; m_run = 0; m_last = 1;
        e_v0 = 0; e_v1 = 0; e_d0 = 0; e_d1 = 0;
    endtask

    function automatic int pick();
        if (!rst_n) return -1;
        if (req0_valid && req1_valid) begin
            if (m_owner >= 0) return (m_run < MB) ? m_owner : 1 - m_owner;
            return 1 - m_last;
        end
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic set_req(input int id, input bit v, input bit we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (id == 0) begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic idle();
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
    endtask

    // advance one clock and update the model with that cycle's accept
    task automatic tick();
        int w; bit we; logic [AW-1:0] a; logic [DW-1:0] d;
        w  = pick();
        we = (w == 1) ? req1_we : req0_we;
        a  = (w == 1) ? req1_addr : req0_addr;
        d  = (w == 1) ? req1_wdata : req0_wdata;
        @(posedge clk);
        e_v0 = 0; e_v1 = 0;
        if (w < 0) begin
            m_owner = -1; m_run = 0;
        end else begin
            m_run   = (w == m_owner) ? m_run + 1 : 1;
            m_owner = w; m_last = w;
            if (we) m_mem[a] = d;
            else if (w == 0) begin e_v0 = 1; e_d0 = m_mem[a]; end
            else begin e_v1 = 1; e_d1 = m_mem[a]; end
        end
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 0;
        set_req(0, 1, 1, 4'h5, 8'h77);
        set_req(1, 1, 0, 4'h6, 8'h00);
        #1;
        checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL reset_ready0 got=%b exp=0", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL reset_ready1 got=%b exp=0", req1_ready); end
        checks++; if ({mem_we, mem_addr, mem_wdata} !== '0) begin failures++; $display("FAIL reset_mem got=%b/%h/%h exp=0", mem_we, mem_addr, mem_wdata); end
        checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin failures++; $display("FAIL reset_rspv got=%b%b exp=00", rsp0_valid, rsp1_valid); end
        checks++; if ({rsp0_rdata, rsp1_rdata} !== '0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0", rsp0_rdata, rsp1_rdata); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (sram[5] !== 8'h00) begin failures++; $display("FAIL reset_nowrite got=%h exp=00", sram[5]); end
        @(negedge clk);
        idle();
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_tie();
        @(negedge clk);
        set_req(0, 1, 0, 4'h0, 0);
        set_req(1, 1, 0, 4'h0, 0);
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL tie_first got=%b%b exp=10", req0_ready, req1_ready); end
        tick();
        @(negedge clk);
        set_req(0, 0, 0, 0, 0);
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b01) begin failures++; $display("FAIL tie_second got=%b%b exp=01", req0_ready, req1_ready); end
        checks++; if ({rsp0_valid, rsp1_valid} !== 2'b10) begin failures++; $display("FAIL tie_rsp0 got=%b%b exp=10", rsp0_valid, rsp1_valid); end
        tick();
        @(negedge clk);
        idle();
        #1;
        checks++; if ({rsp0_valid, rsp1_valid} !== 2'b01) begin failures++; $display("FAIL tie_rsp1 got=%b%b exp=01", rsp0_valid, rsp1_valid); end
        tick();
    endtask

    task automatic test_solo_write_read();
        @(negedge clk);
        set_req(0, 1, 1, 4'h3, 8'hA5);
        #1;
        checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL wr_ready got=%b exp=1", req0_ready); end
        checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 4'h3, 8'hA5}) begin failures++; $display("FAIL wr_mem got=%b/%h/%h exp=1/3/a5", mem_we, mem_addr, mem_wdata); end
        tick();
        checks++; if (rsp0_valid !== 1'b0) begin failures++; $display("FAIL wr_norsp got=%b exp=0", rsp0_valid); end
        @(negedge clk);
        set_req(0, 1, 0, 4'h3, 0);
        #1;
        checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL rd_ready got=%b exp=1", req0_ready); end
        tick();
        checks++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 8'hA5) begin failures++; $display("FAIL rd_data got=%b/%h exp=1/a5", rsp0_valid, rsp0_rdata); end
        checks++; if (rsp1_valid !== 1'b0) begin failures++; $display("FAIL rd_rsp1 got=%b exp=0", rsp1_valid); end
        @(negedge clk);
        idle();
        tick();
        checks++; if (rsp0_valid !== 1'b0 || rsp0_rdata !== 8'hA5) begin failures++; $display("FAIL rd_pulse got=%b/%h exp=0/a5", rsp0_valid, rsp0_rdata); end
    endtask

    task automatic test_burst_limit();
        int a0 = 0; bit r1_done = 0; int cyc = 0; int r1_cyc = -1;
        int r1_wait = 0; int max_wait = 0;
        while ((a0 < 10 || !r1_done) && cyc < 20) begin
            @(negedge clk);
            set_req(0, a0 < 10, 0, AW'(a0), 0);
            set_req(1, cyc >= 1 && !r1_done, 0, 4'hE, 0);
            #1;
            checks++; if ({req0_ready, req1_ready} !== {pick() == 0, pick() == 1}) begin failures++; $display("FAIL burst_ready cyc=%0d got=%b%b exp=%b%b", cyc, req0_ready, req1_ready, pick() == 0, pick() == 1); end
            if (req1_valid && !req1_ready) r1_wait++;
            if (req1_valid && req1_ready) begin r1_done = 1; r1_cyc = cyc; end
            if (r1_wait > max_wait) max_wait = r1_wait;
            if (req0_valid && req0_ready) a0++;
            tick();
            checks++; if (rsp0_valid !== e_v0 || (e_v0 && rsp0_rdata !== e_d0)) begin failures++; $display("FAIL burst_rsp0 cyc=%0d got=%b/%h exp=%b/%h", cyc, rsp0_valid, rsp0_rdata, e_v0, e_d0); end
            cyc++;
        end
        checks++; if (r1_cyc !== 4) begin failures++; $display("FAIL burst_r1_slot got=%0d exp=4", r1_cyc); end
        checks++; if (cyc !== 11) begin failures++; $display("FAIL burst_total got=%0d exp=11", cyc); end
        checks++; if (max_wait > MB) begin failures++; $display("FAIL burst_wait got=%0d exp<=%0d", max_wait, MB); end
        @(negedge clk);
        idle();
        tick();
    endtask

    task automatic test_solo_over_limit();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            set_req(1, 1, 1, AW'(k), DW'(8'h10 + k));
            #1;
            checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL solo_wr k=%0d got=%b exp=1", k, req1_ready); end
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            set_req(1, 1, 0, AW'(k), 0);
            #1;
            tick();
            checks++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== DW'(8'h10 + k)) begin failures++; $display("FAIL solo_rd k=%0d got=%b/%h exp=1/%h", k, rsp1_valid, rsp1_rdata, 8'h10 + k); end
        end
        @(negedge clk);
        idle();
        tick();
    endtask

    task automatic test_hazard();
        @(negedge clk);
        set_req(1, 1, 1, 4'h7, 8'h3C);
        #1;
        checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL haz_wr got=%b exp=1", req1_ready); end
        tick();
        @(negedge clk);
        set_req(1, 0, 0, 0, 0);
        set_req(0, 1, 0, 4'h7, 0);
        #1;
        checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL haz_rd_ready got=%b exp=1", req0_ready); end
        tick();
        checks++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 8'h3C) begin failures++; $display("FAIL haz_data got=%b/%h exp=1/3c", rsp0_valid, rsp0_rdata); end
        @(negedge clk);
        idle();
        tick();
    endtask

    task automatic test_random();
        bit pend [2]; bit we [2]; logic [AW-1:0] a [2]; logic [DW-1:0] d [2];
        int wt [2]; int w;
        pend = '{0, 0}; wt = '{0, 0};
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 3) != 0) begin
                    pend[i] = 1;
                    we[i] = $urandom_range(0, 1);
                    a[i] = AW'($urandom_range(0, 15));
                    d[i] = DW'($urandom);
                end
                set_req(i, pend[i], we[i], a[i], d[i]);
            end
            #1;
            w = pick();
            checks++; if ({req0_ready, req1_ready} !== {w == 0, w == 1}) begin failures++; $display("FAIL rnd_ready c=%0d got=%b%b exp=%b%b", c, req0_ready, req1_ready, w == 0, w == 1); end
            checks++;
            if (w < 0) begin
                if ({mem_we, mem_addr, mem_wdata} !== '0) begin failures++; $display("FAIL rnd_mem_idle c=%0d got=%b/%h/%h exp=0", c, mem_we, mem_addr, mem_wdata); end
            end else if (mem_we !== we[w] || mem_addr !== a[w] || mem_wdata !== d[w]) begin
                failures++; $display("FAIL rnd_mem c=%0d got=%b/%h/%h exp=%b/%h/%h", c, mem_we, mem_addr, mem_wdata, we[w], a[w], d[w]);
            end
            for (int i = 0; i < 2; i++) begin
                if (pend[i] && w != i) wt[i]++;
                else wt[i] = 0;
            end
            checks++; if (wt[0] > MB || wt[1] > MB) begin failures++; $display("FAIL rnd_wait c=%0d got=%0d/%0d exp<=%0d", c, wt[0], wt[1], MB); end
            tick();
            if (w >= 0) pend[w] = 0;
            checks++; if (rsp0_valid !== e_v0 || rsp0_rdata !== e_d0) begin failures++; $display("FAIL rnd_rsp0 c=%0d got=%b/%h exp=%b/%h", c, rsp0_valid, rsp0_rdata, e_v0, e_d0); end
            checks++; if (rsp1_valid !== e_v1 || rsp1_rdata !== e_d1) begin failures++; $display("FAIL rnd_rsp1 c=%0d got=%b/%h exp=%b/%h", c, rsp1_valid, rsp1_rdata, e_v1, e_d1); end
        end
        @(negedge clk);
        idle();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            set_req(0, 1, 0, AW'(k), 0);
            #1;
            tick();
        end
        @(negedge clk);
        set_req(0, 1, 0, 4'h2, 0);
        #1;
        checks++; if (req0_ready !== 1'b1 || rsp0_valid !== 1'b1) begin failures++; $display("FAIL rmb_pre got=%b/%b exp=1/1", req0_ready, rsp0_valid); end
        rst_n = 0;
        #1;
        model_reset();
        checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL rmb_ready got=%b exp=0", req0_ready); end
        checks++; if ({mem_we, mem_addr} !== '0) begin failures++; $display("FAIL rmb_mem got=%b/%h exp=0", mem_we, mem_addr); end
        checks++; if (rsp0_valid !== 1'b0 || rsp0_rdata !== 8'h00) begin failures++; $display("FAIL rmb_rsp got=%b/%h exp=0/00", rsp0_valid, rsp0_rdata); end
        @(posedge clk);
        #1;
        checks++; if (rsp0_valid !== 1'b0) begin failures++; $display("FAIL rmb_noacc got=%b exp=0", rsp0_valid); end
        @(negedge clk);
        rst_n = 1;
        set_req(0, 1, 0, 4'h5, 0);
        set_req(1, 1, 0, 4'h6, 0);
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL rmb_tie got=%b%b exp=10", req0_ready, req1_ready); end
        tick();
        checks++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== e_d0) begin failures++; $display("FAIL rmb_rd got=%b/%h exp=1/%h", rsp0_valid, rsp0_rdata, e_d0); end
        @(negedge clk);
        idle();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            sram[i] = '0;
            m_mem[i] = '0;
        end
        model_reset();
        test_reset();
        test_tie();
        test_solo_write_read();
        test_burst_limit();
        test_solo_over_limit();
        test_hazard();
        test_random();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
